// File: rtl/timer_count_param.sv
// Timer counter core: count register, up/down direction and overflow-flag trigger.
// Counter length is selected at run time through a mask applied to every stored value.
module timer_count_param #(
   parameter int WIDTH = 16
) (
   input  logic             TimerClock,
   input  logic             reset,
   input  logic             tick,
   input  logic             clr,
   input  logic [1:0]       MC,
   input  logic [1:0]       CNTL,
   input  logic [WIDTH-1:0] period,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             equ0,
   output logic             ifg_set
);

   typedef enum logic [1:0] {
      MC_STOP   = 2'b00,
      MC_UP     = 2'b01,
      MC_CONT   = 2'b10,
      MC_UPDOWN = 2'b11
   } mc_t;

   localparam logic [WIDTH-1:0] ONES = '1;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [WIDTH-1:0] r_count;
   logic             r_dir;
   logic             r_ifg;

   logic [WIDTH-1:0] w_mask;
   logic [WIDTH-1:0] w_cnt_m;
   logic [WIDTH-1:0] w_per_m;
   logic [WIDTH-1:0] w_inc;
   logic [WIDTH-1:0] w_dec;
   logic [WIDTH-1:0] w_count_next;
   logic             w_dir_next;
   logic             w_ifg_next;
   mc_t              w_mode;

   always_comb begin
      w_mask = ONES;
      case (CNTL)
         2'b00:   w_mask = ONES;
         2'b01:   w_mask = ONES >> 4;
         2'b10:   w_mask = ONES >> 6;
         default: w_mask = ONES >> 8;
      endcase
   end

   // A stale count above the new length is folded into range before any step uses it.
   assign w_cnt_m = r_count & w_mask;
   assign w_per_m = period & w_mask;
   assign w_inc   = (w_cnt_m + ONE) & w_mask;
   assign w_dec   = (w_cnt_m - ONE) & w_mask;
   assign w_mode  = mc_t'(MC);

   always_comb begin
      w_count_next = r_count;
      w_dir_next   = r_dir;
      w_ifg_next   = 1'b0;
      if (clr) begin
         w_count_next = '0;
         w_dir_next   = 1'b0;
      end else if (wr_en) begin
         w_count_next = wr_data & w_mask;
      end else if (tick) begin
         case (w_mode)
            MC_UP: begin
               if (w_per_m == '0) begin
                  w_count_next = '0;
               end else if (w_cnt_m == w_per_m) begin
                  w_count_next = '0;
                  w_ifg_next   = 1'b1;
               end else begin
                  w_count_next = w_inc;
                  w_ifg_next   = (w_inc == '0);
               end
            end
            MC_CONT: begin
               w_count_next = w_inc;
               w_ifg_next   = (w_inc == '0);
            end
            MC_UPDOWN: begin
               if (w_per_m == '0) begin
                  w_count_next = '0;
                  w_dir_next   = 1'b0;
               end else if (!r_dir && (w_cnt_m < w_per_m)) begin
                  w_count_next = w_inc;
               end else begin
                  // Turn-around and down steps share one path; reaching 0 ends the down leg.
                  w_count_next = w_dec;
                  if (w_dec == '0) begin
                     w_dir_next = 1'b0;
                     w_ifg_next = 1'b1;
                  end else begin
                     w_dir_next = 1'b1;
                  end
               end
            end
            default: begin
               w_count_next = r_count;
            end
         endcase
      end
   end

   always_ff @(posedge TimerClock) begin
      if (reset) begin
         r_count <= '0;
         r_dir   <= 1'b0;
         r_ifg   <= 1'b0;
      end else begin
         r_count <= w_count_next;
         r_dir   <= w_dir_next;
         r_ifg   <= w_ifg_next;
      end
   end

   assign count   = r_count;
   assign dir     = r_dir;
   assign ifg_set = r_ifg;
   assign equ0    = (r_count == w_per_m);

endmodule

// File: tb/tb_timer_count_param.sv
// Directed bench for timer_count_param: expected values are queued per step and
// compared against the registered outputs one time unit after each rising edge.
module tb_timer_count_param;

   logic        clk;
   logic        reset;
   logic        tick;
   logic        clr;
   logic [1:0]  MC;
   logic [1:0]  CNTL;
   logic [15:0] period;
   logic        wr_en;
   logic [15:0] wr_data;
   logic [15:0] count;
   logic        dir;
   logic        equ0;
   logic        ifg_set;

   typedef struct {
      string       tag;
      logic [15:0] cnt;
      logic        dir;
      logic        ifg;
      logic        equ;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   fails = 0;

   timer_count_param #(.WIDTH(16)) dut (
      .TimerClock (clk),
      .reset      (reset),
      .tick       (tick),
      .clr        (clr),
      .MC         (MC),
      .CNTL       (CNTL),
      .period     (period),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .count      (count),
      .dir        (dir),
      .equ0       (equ0),
      .ifg_set    (ifg_set)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
      end
   endtask

   // Queue the expectation, clock once, then pop and compare.
   task automatic go(input string tag, input logic [15:0] c, input logic d,
                     input logic ifg, input logic e);
      exp_t x;
      x.tag = tag; x.cnt = c; x.dir = d; x.ifg = ifg; x.equ = e;
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      $display("%-10s count=%04h dir=%b ifg=%b equ0=%b", x.tag, count, dir, ifg_set, equ0);
      check({x.tag, ".count"}, 32'(count),   32'(x.cnt));
      check({x.tag, ".dir"},   32'(dir),     32'(x.dir));
      check({x.tag, ".ifg"},   32'(ifg_set), 32'(x.ifg));
      check({x.tag, ".equ0"},  32'(equ0),    32'(x.equ));
   endtask

   initial begin
      logic [15:0] c;
      reset = 1'b1; tick = 1'b0; clr = 1'b0; MC = 2'b01; CNTL = 2'b00;
      period = 16'd3; wr_en = 1'b0; wr_data = 16'h0000;
      go("reset", 16'h0000, 0, 0, 0);

      // UP, period 3
      reset = 1'b0; tick = 1'b1;
      go("up1", 16'd1, 0, 0, 0);
      go("up2", 16'd2, 0, 0, 0);
      go("up3", 16'd3, 0, 0, 1);
      go("up0", 16'd0, 0, 1, 0);
      go("up1b", 16'd1, 0, 0, 0);

      // UPDOWN, period 3
      MC = 2'b11; clr = 1'b1;
      go("ud_clr", 16'd0, 0, 0, 0);
      clr = 1'b0;
      go("ud1", 16'd1, 0, 0, 0);
      go("ud2", 16'd2, 0, 0, 0);
      go("ud3", 16'd3, 0, 0, 1);
      go("ud2d", 16'd2, 1, 0, 0);
      go("ud1d", 16'd1, 1, 0, 0);
      go("ud0", 16'd0, 0, 1, 0);
      go("ud1u", 16'd1, 0, 0, 0);

      // CONTINUOUS with 8-bit length
      MC = 2'b10; CNTL = 2'b11; wr_en = 1'b1; wr_data = 16'h00FE;
      go("co_wr", 16'h00FE, 0, 0, 0);
      wr_en = 1'b0;
      go("co_ff", 16'h00FF, 0, 0, 0);
      go("co_00", 16'h0000, 0, 1, 0);
      CNTL = 2'b00; wr_en = 1'b1; wr_data = 16'hFFFF;
      go("co_wrff", 16'hFFFF, 0, 0, 0);
      wr_en = 1'b0;
      go("co_wrap", 16'h0000, 0, 1, 0);
      CNTL = 2'b11; wr_en = 1'b1; wr_data = 16'h1234;
      go("co_mask", 16'h0034, 0, 0, 0);
      wr_en = 1'b0; CNTL = 2'b00;

      // UP, period 5, count above period runs to full scale
      MC = 2'b01; period = 16'd5; wr_en = 1'b1; wr_data = 16'd10;
      go("upb_wr", 16'd10, 0, 0, 0);
      wr_en = 1'b0;
      go("upb_11", 16'd11, 0, 0, 0);
      wr_en = 1'b1; wr_data = 16'hFFFD;
      go("upb_wr2", 16'hFFFD, 0, 0, 0);
      wr_en = 1'b0;
      go("upb_fe", 16'hFFFE, 0, 0, 0);
      go("upb_ff", 16'hFFFF, 0, 0, 0);
      go("upb_0", 16'h0000, 0, 1, 0);
      for (int k = 1; k <= 5; k++) go("upb_n", 16'(k), 0, 0, (k == 5));

      // Simultaneous events
      clr = 1'b1;
      go("tick_clr", 16'd0, 0, 0, 0);
      clr = 1'b0; wr_en = 1'b1; wr_data = 16'h1234;
      go("tick_wr", 16'h1234, 0, 0, 0);
      wr_en = 1'b0; MC = 2'b10; CNTL = 2'b11;
      go("stale_m", 16'h0035, 0, 0, 0);
      reset = 1'b1; wr_en = 1'b1; wr_data = 16'h5555; CNTL = 2'b00;
      go("rst_wr", 16'h0000, 0, 0, 0);
      reset = 1'b0; wr_en = 1'b0;

      // period_m == 0 holds at 0
      MC = 2'b01; CNTL = 2'b11; period = 16'h0100;
      go("per0_a", 16'h0000, 0, 0, 1);
      go("per0_b", 16'h0000, 0, 0, 1);
      CNTL = 2'b00; period = 16'd5;

      // tick every 4th cycle
      c = 16'd0;
      for (int k = 0; k < 12; k++) begin
         tick = (k % 4 == 3);
         if (tick) c = c + 16'd1;
         go("gate", c, 0, 0, 0);
      end

      // STOP holds count and dir, then UPDOWN resumes downward
      tick = 1'b1; MC = 2'b11; period = 16'd3; clr = 1'b1;
      go("st_clr", 16'd0, 0, 0, 0);
      clr = 1'b0;
      go("st_1", 16'd1, 0, 0, 0);
      go("st_2", 16'd2, 0, 0, 0);
      go("st_3", 16'd3, 0, 0, 1);
      go("st_2d", 16'd2, 1, 0, 0);
      MC = 2'b00;
      for (int k = 0; k < 10; k++) go("stop", 16'd2, 1, 0, 0);
      MC = 2'b11;
      go("res_1", 16'd1, 1, 0, 0);
      go("res_0", 16'd0, 0, 1, 0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
